// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among 4 byte requesters; handshake in IDLE, tx_start the next cycle.
// Backpressure: req_ready only in IDLE with tx_busy low. Optional tag-byte prefix enabled by `define UART_TX_TAG_EN.
module uart_tx_arbiter #(
    parameter logic [7:0] TAG_BASE    = 8'h30,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic        clk_fpga,
    input  logic        reset_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        active
);

`ifdef UART_TX_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_TAG,
        SEND_DATA,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      rr_ptr;
    logic [7:0]      data_q;
    logic            is_tag;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            win_vld;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic            hs;
    logic            byte_done;
    logic [7:0]      tag_byte;

    // Search starts one past the last winner and wraps, so rr_ptr itself is tried last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        cand    = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        hs        = 1'b0;
        byte_done = 1'b0;
        case (state)
            IDLE: begin
                if (reset_n && !tx_busy && win_vld) begin
                    hs        = 1'b1;
                    state_nxt = TAG_EN ? SEND_TAG : SEND_DATA;
                end
            end
            SEND_TAG, SEND_DATA: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte as if sent.
                    byte_done = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) byte_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (byte_done) state_nxt = is_tag ? SEND_DATA : IDLE;
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= 2'd3;
            grant_id <= 2'd0;
            data_q   <= 8'h00;
            is_tag   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hs) begin
                rr_ptr   <= win_idx;
                grant_id <= win_idx;
                data_q   <= req_data[{win_idx, 3'b000} +: 8];
                is_tag   <= TAG_EN;
            end else if (byte_done && is_tag) begin
                is_tag <= 1'b0;
            end
        end
    end

    // tx_data follows registered state only, so it holds between start pulses.
    assign tag_byte  = TAG_BASE + {6'b000000, grant_id};
    assign tx_data   = is_tag ? tag_byte : data_q;
    assign tx_start  = (state == SEND_TAG) || (state == SEND_DATA);
    assign active    = (state != IDLE);
    assign req_ready = hs ? 4'(4'b0001 << win_idx) : 4'b0000;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a round-robin queue model.
module tb_uart_tx_arbiter;

    localparam int ACK = 15;

    logic        clk_fpga = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;

    int n_chk = 0;
    int n_pass = 0;
    int last_grant = 3;

    always #5 clk_fpga = ~clk_fpga;

    uart_tx_arbiter #(.TAG_BASE(8'h30), .ACK_TIMEOUT(ACK)) dut (
        .clk_fpga  (clk_fpga),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    task automatic step();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++)
            if (v[(last + k) % 4]) return (last + k) % 4;
        return 0;
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        tx_busy   = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("rst_active", active, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);
        step();
        reset_n    = 1'b1;
        last_grant = 3;
    endtask

    // Called in the cycle a byte's tx_start is expected; returns one cycle after the byte completes.
    task automatic send_byte(input logic [7:0] exp, input int w, input int d, input int len, input bit silent);
        chk("tx_start", tx_start, 1);
        chk("tx_data", tx_data, exp);
        chk("grant_id", grant_id, w);
        if (silent) begin
            for (int k = 0; k < ACK; k++) begin
                step();
                chk("ack_wait_active", active, 1);
                chk("ack_wait_start", tx_start, 0);
                chk("ack_wait_hold", tx_data, exp);
            end
            step();
        end else begin
            repeat (d) begin
                step();
                chk("pre_busy_active", active, 1);
                chk("pre_busy_start", tx_start, 0);
            end
            tx_busy = 1'b1;
            repeat (len) begin
                step();
                chk("busy_active", active, 1);
                chk("busy_start", tx_start, 0);
                chk("busy_tx_hold", tx_data, exp);
                chk("busy_grant_hold", grant_id, w);
                chk("busy_ready", req_ready, 0);
            end
            tx_busy = 1'b0;
            step();
        end
    endtask

    task automatic do_txn(input int d, input int len, input bit silent);
        int w;
        logic [7:0] b;
        #1;
        w = rr_pick(req_valid, last_grant);
        chk("idle_active", active, 0);
        chk("req_ready", req_ready, 32'(1) << w);
        b = req_data[8*w +: 8];
        step();
        last_grant   = w;
        req_valid[w] = 1'b0;
`ifdef UART_TX_TAG_EN
        send_byte(8'(8'h30 + w), w, d, len, silent);
`endif
        send_byte(b, w, d, len, silent);
        chk("done_active", active, 0);
        chk("done_start", tx_start, 0);
    endtask

    initial begin
        req_data = 32'h0;
        do_reset();

        // single request, requester 2, byte 0x41
        req_valid = 4'b0100;
        req_data  = 32'h0041_0000;
        do_txn(1, 3, 1'b0);
        chk("single_grant", grant_id, 2);

        // busy transmitter blocks arbitration in IDLE
        tx_busy       = 1'b1;
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h55;
        #1;
        chk("busy_idle_ready", req_ready, 0);
        step();
        chk("busy_idle_active", active, 0);
        tx_busy = 1'b0;
        do_txn(0, 2, 1'b0);

        // contention: all four held after reset
        do_reset();
        req_data = 32'h4443_4241;
        for (int t = 0; t < 5; t++) begin
            req_valid = 4'hF;
            do_txn(t % 4, 2 + t % 3, 1'b0);
            chk("rr_order", grant_id, t % 4);
        end

        // requester 1 sends 0x7A (tag 0x31 first when tags enabled)
        req_valid      = 4'b0010;
        req_data[15:8] = 8'h7A;
        do_txn(2, 4, 1'b0);

        // silent transmitter: timeout then next request accepted
        req_valid = 4'b1000;
        do_txn(0, 0, 1'b1);
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h99;
        do_txn(1, 2, 1'b0);

        // reset during WAIT_DONE
        req_valid = 4'b0100;
        #1;
        step();
        tx_busy = 1'b1;
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_active", active, 0);
        chk("mid_rst_start", tx_start, 0);
        chk("mid_rst_data", tx_data, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_ready", req_ready, 0);
        req_valid = 4'hF;
        step();
        reset_n    = 1'b1;
        last_grant = 3;
        repeat (3) begin
            step();
            chk("post_rst_start", tx_start, 0);
            chk("post_rst_active", active, 0);
            chk("post_rst_ready", req_ready, 0);
        end
        tx_busy = 1'b0;
        do_txn(1, 2, 1'b0);
        chk("post_rst_grant", grant_id, 0);

        // randomized traffic; requesters hold valid and data until accepted
        req_valid = 4'b0000;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if (req_valid == 4'b0000) begin
                req_valid[t % 4]         = 1'b1;
                req_data[8*(t % 4) +: 8] = 8'($urandom);
            end
            do_txn($urandom_range(0, 3), $urandom_range(2, 5), $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
